// File: rtl/ahb_lite_manager_pkg.sv
// Shared AHB-Lite encodings and the manager FSM state type.
package ahb_lite_manager_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HBURST: only single transfers are issued
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // HPROT: data access, privileged, non-bufferable, non-cacheable
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    // HSIZE encodings (bytes per beat = 2**hsize)
    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;
    localparam logic [2:0] HSIZE_128   = 3'b100;
    localparam logic [2:0] HSIZE_256   = 3'b101;
    localparam logic [2:0] HSIZE_512   = 3'b110;
    localparam logic [2:0] HSIZE_1024  = 3'b111;

    // Manager FSM states; one transfer outstanding at a time
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

endpackage

// File: rtl/ahb_lite_manager.sv
// Single-transfer AHB-Lite manager: turns a valid/ready request into one
// NONSEQ SINGLE transfer and returns the result on a valid/ready response.
module ahb_lite_manager
    import ahb_lite_manager_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    // request channel
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_write_i,
    input  logic [AHB_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [2:0]                  req_size_i,
    input  logic [AHB_DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [AHB_DATA_WIDTH/8-1:0] req_wstrb_i,
    // response channel
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [AHB_DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                        rsp_err_o,
    // AHB-Lite manager outputs
    output logic [AHB_ADDR_WIDTH-1:0]   haddr_o,
    output logic [2:0]                  hburst_o,
    output logic [3:0]                  hprot_o,
    output logic [2:0]                  hsize_o,
    output logic [1:0]                  htrans_o,
    output logic [AHB_DATA_WIDTH-1:0]   hwdata_o,
    output logic [AHB_DATA_WIDTH/8-1:0] hwstrb_o,
    output logic                        hwrite_o,
    output logic                        hsel_o,
    output logic                        hready_o,
    // AHB-Lite inputs
    input  logic [AHB_DATA_WIDTH-1:0]   hrdata_i,
    input  logic                        hreadyout_i,
    input  logic                        hresp_i
);

    localparam int STRB_WIDTH = AHB_DATA_WIDTH / 8;

    state_t                    state;
    logic [AHB_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0]     wstrb_q;
    logic                      err_q;     // ERROR seen during the data phase
    logic [7:0]                size_bytes;
    logic                      req_illegal;

    assign hburst_o    = HBURST_SINGLE;
    assign hprot_o     = HPROT_DEFAULT;
    assign hready_o    = hreadyout_i;
    // Held low during reset so nothing is accepted while the bus is cleared.
    assign req_ready_o = (state == ST_IDLE) && !rst_i;

    // Reject requests wider than the bus or not aligned to their own size.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path; a missed
        // assignment would infer a latch.
        size_bytes  = 8'd1 << req_size_i;
        req_illegal = (int'(size_bytes) > STRB_WIDTH) ||
                      ((req_addr_i[7:0] & (size_bytes - 8'd1)) != 8'd0);
    end

    // Transfer FSM with registered bus and response outputs.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (rst_i) begin
            state       <= ST_IDLE;
            htrans_o    <= HTRANS_IDLE;
            hsel_o      <= 1'b0;
            haddr_o     <= '0;
            hsize_o     <= '0;
            hwrite_o    <= 1'b0;
            hwdata_o    <= '0;
            hwstrb_o    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        haddr_o  <= req_addr_i;
                        hsize_o  <= req_size_i;
                        hwrite_o <= req_write_i;
                        wdata_q  <= req_wdata_i;
                        wstrb_q  <= req_wstrb_i;
                        err_q    <= 1'b0;
                        if (req_illegal) begin
                            // answer immediately, the bus is never touched
                            state       <= ST_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end else begin
                            state    <= ST_ADDR;
                            htrans_o <= HTRANS_NONSEQ;
                            hsel_o   <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    // address phase is extended while the subordinate stalls
                    if (hreadyout_i) begin
                        state    <= ST_DATA;
                        htrans_o <= HTRANS_IDLE;
                        hsel_o   <= 1'b0;
                        hwdata_o <= wdata_q;
                        hwstrb_o <= hwrite_o ? wstrb_q : '0;
                    end
                end
                ST_DATA: begin
                    if (hreadyout_i) begin
                        state       <= ST_RESP;
                        hwstrb_o    <= '0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= err_q | hresp_i;
                        rsp_rdata_o <= (hwrite_o || err_q || hresp_i) ? '0 : hrdata_i;
                    end else if (hresp_i) begin
                        // first cycle of the two-cycle ERROR response
                        err_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state       <= ST_IDLE;
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_manager.sv
// Self-checking bench for ahb_lite_manager: directed vector table, a reset
// sequence and randomized transfers against a timeline reference model.
module tb_ahb_lite_manager;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [2:0]  req_size_i = '0;
    logic [63:0] req_wdata_i = '0;
    logic [7:0]  req_wstrb_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [63:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] haddr_o;
    logic [2:0]  hburst_o;
    logic [3:0]  hprot_o;
    logic [2:0]  hsize_o;
    logic [1:0]  htrans_o;
    logic [63:0] hwdata_o;
    logic [7:0]  hwstrb_o;
    logic        hwrite_o;
    logic        hsel_o;
    logic        hready_o;
    logic [63:0] hrdata_i = '0;
    logic        hreadyout_i = 1'b1;
    logic        hresp_i = 1'b0;

    int total = 0;
    int bad   = 0;

    ahb_lite_manager #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i),
        .req_size_i(req_size_i), .req_wdata_i(req_wdata_i),
        .req_wstrb_i(req_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .haddr_o(haddr_o), .hburst_o(hburst_o), .hprot_o(hprot_o),
        .hsize_o(hsize_o), .htrans_o(htrans_o), .hwdata_o(hwdata_o),
        .hwstrb_o(hwstrb_o), .hwrite_o(hwrite_o), .hsel_o(hsel_o),
        .hready_o(hready_o),
        .hrdata_i(hrdata_i), .hreadyout_i(hreadyout_i), .hresp_i(hresp_i)
    );

    always #5 clk_i = ~clk_i;

    // One transfer: request, subordinate behaviour, expected response.
    // aw/dw = wait states in address/data phase, err = two-cycle ERROR,
    // rd = cycles rsp_ready_i stays low after rsp_valid_o rises.
    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        int          aw;
        int          dw;
        bit          err;
        logic [63:0] hrdata;
        int          rd;
        int          exp_lat;   // cycles from acceptance to rsp_valid_o
        bit          exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected result derived from the transfer rules with plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   bytes;
        bit   illegal;
        r       = v;
        bytes   = 1 << v.size;
        illegal = (bytes > 8) || ((v.addr % 32'(bytes)) != 32'd0);
        r.exp_lat   = illegal ? 1 : 3 + v.aw + v.dw + (v.err ? 1 : 0);
        r.exp_err   = illegal || v.err;
        r.exp_rdata = (!v.write && !r.exp_err) ? v.hrdata : 64'd0;
        return r;
    endfunction

    // Present one request at the current cycle and follow it to the handshake.
    // Entered and left just after a rising edge with the DUT idle.
    task automatic run_txn(input string tag, input vec_t v);
        bit bus;
        int addr_end, data_end, hs_k, j;
        bus      = (v.exp_lat != 1);
        addr_end = 1 + v.aw;
        data_end = addr_end + 1 + v.dw + (v.err ? 1 : 0);
        hs_k     = v.exp_lat + v.rd;

        check({tag, ".req_ready_start"}, req_ready_o, 1'b1);
        req_valid_i = 1'b1;
        req_write_i = v.write;
        req_addr_i  = v.addr;
        req_size_i  = v.size;
        req_wdata_i = v.wdata;
        req_wstrb_i = v.wstrb;
        hreadyout_i = 1'b1;
        hresp_i     = 1'b0;
        rsp_ready_i = 1'b0;

        for (int k = 1; k <= hs_k + 1; k++) begin
            @(posedge clk_i); #1;
            // scramble request fields so only the latched copy can be used
            req_valid_i = 1'b0;
            req_write_i = 1'($urandom);
            req_addr_i  = $urandom;
            req_size_i  = 3'($urandom);
            req_wdata_i = {$urandom, $urandom};
            req_wstrb_i = 8'($urandom);

            // observe cycle k
            if (bus && k <= addr_end) begin
                check({tag, ".htrans_addr"}, htrans_o, 2'b10);
                check({tag, ".hsel"}, hsel_o, 1'b1);
                check({tag, ".haddr"}, haddr_o, v.addr);
                check({tag, ".hsize"}, hsize_o, v.size);
                check({tag, ".hwrite"}, hwrite_o, v.write);
            end else begin
                check({tag, ".htrans_idle"}, htrans_o, 2'b00);
            end
            if (bus && k > addr_end && k <= data_end) begin
                check({tag, ".hwdata"}, hwdata_o, v.wdata);
                check({tag, ".hwstrb"}, hwstrb_o, v.write ? v.wstrb : 8'h00);
            end
            check({tag, ".rsp_valid"}, rsp_valid_o, (k >= v.exp_lat) && (k <= hs_k));
            if (k >= v.exp_lat && k <= hs_k) begin
                check({tag, ".rsp_err"}, rsp_err_o, v.exp_err);
                check({tag, ".rsp_rdata"}, rsp_rdata_o, v.exp_rdata);
            end
            check({tag, ".req_ready"}, req_ready_o, k > hs_k);

            // drive subordinate and response side for cycle k
            hreadyout_i = 1'b1;
            hresp_i     = 1'b0;
            hrdata_i    = {$urandom, $urandom};
            if (bus && k <= addr_end) begin
                hreadyout_i = (k == addr_end);
            end else if (bus && k <= data_end) begin
                j = k - addr_end;
                if (j <= v.dw) begin
                    hreadyout_i = 1'b0;
                end else if (v.err) begin
                    hresp_i     = 1'b1;
                    hreadyout_i = (j == v.dw + 2);
                end
                if (k == data_end) hrdata_i = v.hrdata;
            end
            rsp_ready_i = (k == hs_k);
            #1;
            check({tag, ".hready_pass"}, hready_o, hreadyout_i);
        end
        rsp_ready_i = 1'b0;
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        //           wr    addr      sz    wdata                  wstrb  aw dw err hrdata                 rd lat err rdata
        tbl[0] = '{1'b1, 32'h40, 3'd2, 64'h1122334455667788, 8'h0F, 0, 0, 1'b0, 64'h0,                0, 3, 1'b0, 64'h0};
        tbl[1] = '{1'b0, 32'h48, 3'd3, 64'h0,                8'hFF, 3, 0, 1'b0, 64'hDEADBEEFCAFEF00D, 0, 6, 1'b0, 64'hDEADBEEFCAFEF00D};
        tbl[2] = '{1'b0, 32'h44, 3'd3, 64'h0,                8'hFF, 0, 0, 1'b0, 64'h5555AAAA5555AAAA, 0, 1, 1'b1, 64'h0};
        tbl[3] = '{1'b1, 32'h10, 3'd2, 64'hA5A5A5A5A5A5A5A5, 8'hF0, 0, 0, 1'b1, 64'h0,                0, 4, 1'b1, 64'h0};
        tbl[4] = '{1'b0, 32'h20, 3'd3, 64'h0,                8'h00, 0, 0, 1'b0, 64'h0123456789ABCDEF, 5, 3, 1'b0, 64'h0123456789ABCDEF};
        tbl[5] = '{1'b0, 32'h00, 3'd4, 64'h0,                8'h00, 0, 0, 1'b0, 64'h1111111111111111, 0, 1, 1'b1, 64'h0};
        tbl[6] = '{1'b0, 32'h03, 3'd0, 64'h0,                8'h00, 2, 0, 1'b0, 64'h00000000000000C3, 1, 5, 1'b0, 64'h00000000000000C3};
        tbl[7] = '{1'b0, 32'h30, 3'd1, 64'h0,                8'h00, 0, 1, 1'b1, 64'h7777777777777777, 0, 5, 1'b1, 64'h0};
        tbl[8] = '{1'b1, 32'h31, 3'd1, 64'hFFFF0000FFFF0000, 8'h03, 0, 0, 1'b0, 64'h0,                0, 1, 1'b1, 64'h0};

        // reset state, with a pending request that must be ignored
        req_valid_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst.htrans", htrans_o, 2'b00);
        check("rst.hsel", hsel_o, 1'b0);
        check("rst.haddr", haddr_o, 32'h0);
        check("rst.hwdata", hwdata_o, 64'h0);
        check("rst.hwstrb", hwstrb_o, 8'h0);
        check("rst.hwrite", hwrite_o, 1'b0);
        check("rst.hsize", hsize_o, 3'h0);
        check("rst.rsp_valid", rsp_valid_o, 1'b0);
        check("rst.rsp_err", rsp_err_o, 1'b0);
        check("rst.rsp_rdata", rsp_rdata_o, 64'h0);
        check("rst.req_ready", req_ready_o, 1'b0);
        check("rst.hburst", hburst_o, 3'b000);
        check("rst.hprot", hprot_o, 4'b0011);
        req_valid_i = 1'b0;
        rst_i       = 1'b0;
        @(posedge clk_i); #1;
        check("rst.release_ready", req_ready_o, 1'b1);
        check("rst.release_htrans", htrans_o, 2'b00);

        // directed vector table
        for (int i = 0; i < 9; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

        // reset while a read sits in its data phase
        check("mid.req_ready", req_ready_o, 1'b1);
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h50;
        req_size_i  = 3'd3; hreadyout_i = 1'b1; hresp_i = 1'b0;
        @(posedge clk_i); #1;                       // address phase
        req_valid_i = 1'b0;
        check("mid.htrans_addr", htrans_o, 2'b10);
        @(posedge clk_i); #1;                       // data phase, subordinate stalls
        hreadyout_i = 1'b0;
        rst_i       = 1'b1;
        @(posedge clk_i); #1;
        check("mid.htrans", htrans_o, 2'b00);
        check("mid.hsel", hsel_o, 1'b0);
        check("mid.haddr", haddr_o, 32'h0);
        check("mid.rsp_valid", rsp_valid_o, 1'b0);
        check("mid.ready_in_rst", req_ready_o, 1'b0);
        rst_i       = 1'b0;
        hreadyout_i = 1'b1;
        @(posedge clk_i); #1;
        check("mid.rsp_valid_after", rsp_valid_o, 1'b0);
        rv = '{1'b1, 32'h60, 3'd3, 64'hCAFEBABE12345678, 8'hFF, 0, 0, 1'b0, 64'h0, 0, 0, 1'b0, 64'h0};
        run_txn("post_rst", model(rv));

        // randomized transfers against the reference model
        for (int i = 0; i < 60; i++) begin
            rv.write  = 1'($urandom);
            rv.size   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            rv.addr   = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 3) != 0 && rv.size <= 3'd3)
                rv.addr = rv.addr & ~((32'd1 << rv.size) - 32'd1);
            rv.wdata  = {$urandom, $urandom};
            rv.wstrb  = 8'($urandom);
            rv.aw     = $urandom_range(0, 2);
            rv.dw     = $urandom_range(0, 2);
            rv.err    = ($urandom_range(0, 5) == 0);
            rv.hrdata = {$urandom, $urandom};
            rv.rd     = $urandom_range(0, 2);
            run_txn($sformatf("rnd%0d", i), model(rv));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
